// File: rtl/adam_axil_arb_ctrl.sv
// Shares one AXI-Lite master port among NO_SLVS requesters: round-robin AW/W and AR grants, index FIFOs route B/R back.
// Grant registers one cycle after request (2-cycle min grant spacing); backpressure passes straight through valid/ready.

module adam_axil_arb_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // Empty head reads as 0 so routing indices are clean after reset.
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_next(wr_q);
            if (do_pop) rd_q <= ptr_next(rd_q);
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module adam_axil_arb_ctrl #(
    parameter int  NO_SLVS   = 4,
    parameter int  MAX_TRANS = 4,
    localparam int SEL_W     = (NO_SLVS > 1) ? $clog2(NO_SLVS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NO_SLVS-1:0] slv_aw_valid,
    output logic [NO_SLVS-1:0] slv_aw_ready,
    input  logic [NO_SLVS-1:0] slv_w_valid,
    output logic [NO_SLVS-1:0] slv_w_ready,
    output logic [NO_SLVS-1:0] slv_b_valid,
    input  logic [NO_SLVS-1:0] slv_b_ready,
    input  logic [NO_SLVS-1:0] slv_ar_valid,
    output logic [NO_SLVS-1:0] slv_ar_ready,
    output logic [NO_SLVS-1:0] slv_r_valid,
    input  logic [NO_SLVS-1:0] slv_r_ready,
    output logic               mst_aw_valid,
    input  logic               mst_aw_ready,
    output logic               mst_w_valid,
    input  logic               mst_w_ready,
    input  logic               mst_b_valid,
    output logic               mst_b_ready,
    output logic               mst_ar_valid,
    input  logic               mst_ar_ready,
    input  logic               mst_r_valid,
    output logic               mst_r_ready,
    output logic [SEL_W-1:0]   aw_sel,
    output logic [SEL_W-1:0]   ar_sel,
    output logic [SEL_W-1:0]   b_sel,
    output logic [SEL_W-1:0]   r_sel,
    input  logic               pause_req,
    output logic               pause_ack,
    output logic               err_unexp
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e           wst_q, wst_d, rst_q, rst_d;
    logic [SEL_W-1:0] aw_sel_q, aw_sel_d, ar_sel_q, ar_sel_d;
    logic [SEL_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic             pause_ack_q, err_q;
    logic             aw_hs, w_hs, aw_fin, w_fin;
    logic             wpush, wpop, wempty, wfull;
    logic             rpush, rpop, rempty, rfull;
    logic [SEL_W-1:0] whead, rhead;

    // First requester at or above ptr, wrapping around.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NO_SLVS-1:0] req,
                                                  input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NO_SLVS; i++) begin
            idx = (int'(ptr) + i) % NO_SLVS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] w);
        return (int'(w) == NO_SLVS - 1) ? '0 : w + 1'b1;
    endfunction

    always_comb begin
        wst_d        = wst_q;
        aw_sel_d     = aw_sel_q;
        wptr_d       = wptr_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        slv_aw_ready = '0;
        slv_w_ready  = '0;
        mst_aw_valid = 1'b0;
        mst_w_valid  = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;
        aw_fin       = 1'b0;
        w_fin        = 1'b0;
        wpush        = 1'b0;
        case (wst_q)
            ST_IDLE: begin
                if ((|slv_aw_valid) && !wfull && !pause_req) begin
                    aw_sel_d = rr_pick(slv_aw_valid, wptr_q);
                    wptr_d   = rr_next(aw_sel_d);
                    wst_d    = ST_BUSY;
                end
            end
            default: begin
                mst_aw_valid           = slv_aw_valid[aw_sel_q] & ~aw_done_q;
                mst_w_valid            = slv_w_valid[aw_sel_q] & ~w_done_q;
                slv_aw_ready[aw_sel_q] = mst_aw_ready & ~aw_done_q;
                slv_w_ready[aw_sel_q]  = mst_w_ready & ~w_done_q;
                aw_hs  = slv_aw_valid[aw_sel_q] & mst_aw_ready & ~aw_done_q;
                w_hs   = slv_w_valid[aw_sel_q] & mst_w_ready & ~w_done_q;
                aw_fin = aw_done_q | aw_hs;
                w_fin  = w_done_q | w_hs;
                if (aw_fin && w_fin) begin
                    wpush     = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wst_d     = ST_IDLE;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
        endcase
    end

    always_comb begin
        rst_d        = rst_q;
        ar_sel_d     = ar_sel_q;
        rptr_d       = rptr_q;
        slv_ar_ready = '0;
        mst_ar_valid = 1'b0;
        rpush        = 1'b0;
        case (rst_q)
            ST_IDLE: begin
                if ((|slv_ar_valid) && !rfull && !pause_req) begin
                    ar_sel_d = rr_pick(slv_ar_valid, rptr_q);
                    rptr_d   = rr_next(ar_sel_d);
                    rst_d    = ST_BUSY;
                end
            end
            default: begin
                mst_ar_valid           = slv_ar_valid[ar_sel_q];
                slv_ar_ready[ar_sel_q] = mst_ar_ready;
                if (slv_ar_valid[ar_sel_q] && mst_ar_ready) begin
                    rpush = 1'b1;
                    rst_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        slv_b_valid        = '0;
        slv_r_valid        = '0;
        slv_b_valid[whead] = mst_b_valid & ~wempty;
        slv_r_valid[rhead] = mst_r_valid & ~rempty;
        mst_b_ready        = slv_b_ready[whead] & ~wempty;
        mst_r_ready        = slv_r_ready[rhead] & ~rempty;
        wpop               = mst_b_valid & mst_b_ready;
        rpop               = mst_r_valid & mst_r_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q       <= ST_IDLE;
            rst_q       <= ST_IDLE;
            aw_sel_q    <= '0;
            ar_sel_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            pause_ack_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wst_q       <= wst_d;
            rst_q       <= rst_d;
            aw_sel_q    <= aw_sel_d;
            ar_sel_q    <= ar_sel_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            pause_ack_q <= pause_req & (wst_q == ST_IDLE) & (rst_q == ST_IDLE) & wempty & rempty;
            err_q       <= err_q | (mst_b_valid & wempty) | (mst_r_valid & rempty);
        end
    end

    adam_axil_arb_idx_fifo #(.DEPTH(MAX_TRANS), .W(SEL_W)) u_wfifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (wpush),
        .dat_i  (aw_sel_q),
        .pop_i  (wpop),
        .head_o (whead),
        .empty_o(wempty),
        .full_o (wfull)
    );

    adam_axil_arb_idx_fifo #(.DEPTH(MAX_TRANS), .W(SEL_W)) u_rfifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (rpush),
        .dat_i  (ar_sel_q),
        .pop_i  (rpop),
        .head_o (rhead),
        .empty_o(rempty),
        .full_o (rfull)
    );

    assign aw_sel    = aw_sel_q;
    assign ar_sel    = ar_sel_q;
    assign b_sel     = whead;
    assign r_sel     = rhead;
    assign pause_ack = pause_ack_q;
    assign err_unexp = err_q;
endmodule

// File: tb/tb_adam_axil_arb_ctrl.sv
// Scenario bench for adam_axil_arb_ctrl: expected requester indices are queued when stimulus is driven and checked at each handshake.
module tb_adam_axil_arb_ctrl;
    localparam int N  = 4;
    localparam int MT = 4;
    localparam int SW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready;
    logic [N-1:0] slv_b_valid, slv_b_ready, slv_ar_valid, slv_ar_ready;
    logic [N-1:0] slv_r_valid, slv_r_ready;
    logic         mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready;
    logic         mst_b_valid, mst_b_ready, mst_ar_valid, mst_ar_ready;
    logic         mst_r_valid, mst_r_ready;
    logic [SW-1:0] aw_sel, ar_sel, b_sel, r_sel;
    logic         pause_req, pause_ack, err_unexp;
    logic [34:0]  all_outs;

    int total = 0;
    int bad   = 0;
    int aw_q[$];
    int ar_q[$];
    int b_q[$];
    int r_q[$];

    always #5 clk = ~clk;

    assign all_outs = {slv_aw_ready, slv_w_ready, slv_b_valid, slv_ar_ready, slv_r_valid,
                       mst_aw_valid, mst_w_valid, mst_b_ready, mst_ar_valid, mst_r_ready,
                       aw_sel, ar_sel, b_sel, r_sel, pause_ack, err_unexp};

    adam_axil_arb_ctrl #(.NO_SLVS(N), .MAX_TRANS(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
        .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
        .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
        .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready),
        .aw_sel(aw_sel), .ar_sel(ar_sel), .b_sel(b_sel), .r_sel(r_sel),
        .pause_req(pause_req), .pause_ack(pause_ack), .err_unexp(err_unexp)
    );

    task automatic idle_inputs();
        slv_aw_valid = '0; slv_w_valid = '0; slv_ar_valid = '0;
        slv_b_ready  = '1; slv_r_ready = '1;
        mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_ar_ready = 1'b1;
        mst_b_valid  = 1'b0; mst_r_valid = 1'b0; pause_req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL reset_hold: outs=%h want 0", all_outs); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            total++;
            if (all_outs !== '0) begin bad++; $display("FAIL reset_idle: outs=%h want 0", all_outs); end
        end
    endtask

    task automatic test_round_robin();
        int last, e;
        last = -1;
        aw_q = {0, 2, 3, 0, 2, 3, 0, 2};
        for (int c = 0; c < 60 && (aw_q.size() > 0 || b_q.size() > 0); c++) begin
            @(negedge clk);
            slv_aw_valid = (aw_q.size() > 0) ? 4'b1101 : 4'b0000;
            slv_w_valid  = slv_aw_valid;
            mst_b_valid  = (b_q.size() > 0);
            #1;
            if (mst_aw_valid && mst_aw_ready) begin
                e = aw_q.pop_front();
                total++;
                if (slv_aw_ready !== (4'b1 << e) || slv_w_ready !== (4'b1 << e) || aw_sel !== SW'(e)) begin
                    bad++; $display("FAIL rr_grant: aw_rdy=%b w_rdy=%b aw_sel=%0d want req %0d", slv_aw_ready, slv_w_ready, aw_sel, e);
                end
                if (last >= 0) begin
                    total++;
                    if (c - last != 2) begin bad++; $display("FAIL rr_spacing: got %0d cycles want 2", c - last); end
                end
                last = c;
                b_q.push_back(e);
            end
            if (mst_b_valid && mst_b_ready) begin
                e = b_q.pop_front();
                total++;
                if (slv_b_valid !== (4'b1 << e) || b_sel !== SW'(e)) begin
                    bad++; $display("FAIL rr_b_route: b_valid=%b b_sel=%0d want req %0d", slv_b_valid, b_sel, e);
                end
            end
        end
        total++;
        if (aw_q.size() != 0 || b_q.size() != 0) begin
            bad++; $display("FAIL rr_timeout: aw left %0d b left %0d want 0", aw_q.size(), b_q.size());
            aw_q.delete(); b_q.delete();
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        slv_aw_valid = 4'b0010; slv_w_valid = 4'b0010; mst_aw_ready = 1'b0;
        #1;
        total++;
        if (slv_w_ready !== 4'b0000) begin bad++; $display("FAIL wfirst_idle: w_rdy=%b want 0000", slv_w_ready); end
        @(negedge clk); #1;
        total++;
        if (slv_w_ready !== 4'b0010 || slv_aw_ready !== 4'b0000 || aw_sel !== SW'(1)) begin
            bad++; $display("FAIL wfirst_w: w_rdy=%b aw_rdy=%b aw_sel=%0d want 0010/0000/1", slv_w_ready, slv_aw_ready, aw_sel);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            total++;
            if (slv_w_ready !== 4'b0000 || mst_w_valid !== 1'b0 || mst_aw_valid !== 1'b1 || aw_sel !== SW'(1)) begin
                bad++; $display("FAIL wfirst_wait: w_rdy=%b mst_w_vld=%b mst_aw_vld=%b aw_sel=%0d want 0000/0/1/1", slv_w_ready, mst_w_valid, mst_aw_valid, aw_sel);
            end
        end
        @(negedge clk); mst_aw_ready = 1'b1; #1;
        total++;
        if (slv_aw_ready !== 4'b0010 || aw_sel !== SW'(1)) begin
            bad++; $display("FAIL wfirst_aw: aw_rdy=%b aw_sel=%0d want 0010/1", slv_aw_ready, aw_sel);
        end
        b_q.push_back(1);
        @(negedge clk);
        slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1;
        #1;
        total++;
        if (slv_b_valid !== (4'b1 << b_q[0]) || mst_b_ready !== 1'b1) begin
            bad++; $display("FAIL wfirst_b: b_valid=%b b_rdy=%b want req %0d", slv_b_valid, mst_b_ready, b_q[0]);
        end
        void'(b_q.pop_front());
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_max_trans();
        int n, e;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            slv_aw_valid = 4'b0001; slv_w_valid = 4'b0001;
            #1;
            if (mst_aw_valid && mst_aw_ready) begin
                total++;
                if (n >= MT || slv_aw_ready !== 4'b0001) begin
                    bad++; $display("FAIL max_grant: grant #%0d aw_rdy=%b want at most %0d to req 0", n + 1, slv_aw_ready, MT);
                end
                n++;
                b_q.push_back(0);
            end
        end
        total++;
        if (n != MT) begin bad++; $display("FAIL max_count: got %0d writes want %0d", n, MT); end
        @(negedge clk); mst_b_valid = 1'b1; #1;
        total++;
        if (mst_b_ready !== 1'b1 || slv_b_valid !== (4'b1 << b_q[0]) || mst_aw_valid !== 1'b0) begin
            bad++; $display("FAIL max_pop: b_rdy=%b b_valid=%b aw_vld=%b want 1/0001/0", mst_b_ready, slv_b_valid, mst_aw_valid);
        end
        void'(b_q.pop_front());
        @(negedge clk); mst_b_valid = 1'b0; #1;
        total++;
        if (mst_aw_valid !== 1'b0) begin bad++; $display("FAIL max_regrant_early: aw_vld=%b want 0", mst_aw_valid); end
        @(negedge clk); #1;
        total++;
        if (mst_aw_valid !== 1'b1 || slv_aw_ready !== 4'b0001) begin
            bad++; $display("FAIL max_regrant: aw_vld=%b aw_rdy=%b want 1/0001", mst_aw_valid, slv_aw_ready);
        end
        b_q.push_back(0);
        for (int c = 0; c < 20 && b_q.size() > 0; c++) begin
            @(negedge clk);
            slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1;
            #1;
            if (mst_b_ready) begin
                e = b_q.pop_front();
                total++;
                if (slv_b_valid !== (4'b1 << e)) begin bad++; $display("FAIL max_drain: b_valid=%b want req %0d", slv_b_valid, e); end
            end
        end
        total++;
        if (b_q.size() != 0) begin bad++; $display("FAIL max_drain_timeout: %0d left want 0", b_q.size()); b_q.delete(); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_rd_wr_same();
        @(negedge clk);
        slv_aw_valid = 4'b1000; slv_w_valid = 4'b1000; slv_ar_valid = 4'b1000;
        #1;
        @(negedge clk); #1;
        total++;
        if (slv_aw_ready !== 4'b1000 || slv_ar_ready !== 4'b1000 || ar_sel !== SW'(3) || aw_sel !== SW'(3)) begin
            bad++; $display("FAIL rw_grant: aw_rdy=%b ar_rdy=%b aw_sel=%0d ar_sel=%0d want req 3 both", slv_aw_ready, slv_ar_ready, aw_sel, ar_sel);
        end
        b_q.push_back(3); r_q.push_back(3);
        @(negedge clk);
        slv_aw_valid = '0; slv_w_valid = '0; slv_ar_valid = '0; mst_r_valid = 1'b1;
        #1;
        total++;
        if (slv_r_valid !== (4'b1 << r_q[0]) || r_sel !== SW'(r_q[0]) || slv_b_valid !== 4'b0000) begin
            bad++; $display("FAIL rw_r: r_valid=%b r_sel=%0d b_valid=%b want req %0d", slv_r_valid, r_sel, slv_b_valid, r_q[0]);
        end
        void'(r_q.pop_front());
        @(negedge clk); mst_r_valid = 1'b0; mst_b_valid = 1'b1; #1;
        total++;
        if (slv_b_valid !== (4'b1 << b_q[0]) || b_sel !== SW'(b_q[0]) || slv_r_valid !== 4'b0000) begin
            bad++; $display("FAIL rw_b: b_valid=%b b_sel=%0d r_valid=%b want req %0d", slv_b_valid, b_sel, slv_r_valid, b_q[0]);
        end
        void'(b_q.pop_front());
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_pause();
        int e;
        ar_q = {0, 1};
        for (int c = 0; c < 12 && ar_q.size() > 0; c++) begin
            @(negedge clk);
            slv_ar_valid = 4'b0011;
            #1;
            if (mst_ar_valid && mst_ar_ready) begin
                e = ar_q.pop_front();
                total++;
                if (slv_ar_ready !== (4'b1 << e)) begin bad++; $display("FAIL pause_ar: ar_rdy=%b want req %0d", slv_ar_ready, e); end
                r_q.push_back(e);
            end
        end
        total++;
        if (ar_q.size() != 0) begin bad++; $display("FAIL pause_ar_timeout: %0d left want 0", ar_q.size()); ar_q.delete(); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pause_req = 1'b1; slv_ar_valid = 4'b0100; slv_aw_valid = 4'b0100; slv_w_valid = 4'b0100;
            #1;
            total++;
            if (mst_ar_valid !== 1'b0 || mst_aw_valid !== 1'b0 || pause_ack !== 1'b0) begin
                bad++; $display("FAIL pause_block: ar_vld=%b aw_vld=%b ack=%b want 0/0/0", mst_ar_valid, mst_aw_valid, pause_ack);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); mst_r_valid = 1'b1; #1;
            total++;
            if (slv_r_valid !== (4'b1 << r_q[0]) || pause_ack !== 1'b0) begin
                bad++; $display("FAIL pause_r: r_valid=%b ack=%b want req %0d ack 0", slv_r_valid, pause_ack, r_q[0]);
            end
            void'(r_q.pop_front());
        end
        @(negedge clk); mst_r_valid = 1'b0; #1;
        total++;
        if (pause_ack !== 1'b0) begin bad++; $display("FAIL pause_ack_early: ack=%b want 0", pause_ack); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            total++;
            if (pause_ack !== 1'b1 || mst_aw_valid !== 1'b0) begin bad++; $display("FAIL pause_ack: ack=%b aw_vld=%b want 1/0", pause_ack, mst_aw_valid); end
        end
        @(negedge clk); pause_req = 1'b0; #1;
        total++;
        if (pause_ack !== 1'b1 || mst_aw_valid !== 1'b0) begin bad++; $display("FAIL pause_fall: ack=%b aw_vld=%b want 1/0", pause_ack, mst_aw_valid); end
        @(negedge clk); #1;
        total++;
        if (pause_ack !== 1'b0 || slv_aw_ready !== 4'b0100 || slv_ar_ready !== 4'b0100) begin
            bad++; $display("FAIL pause_resume: ack=%b aw_rdy=%b ar_rdy=%b want 0/0100/0100", pause_ack, slv_aw_ready, slv_ar_ready);
        end
        b_q.push_back(2); r_q.push_back(2);
        @(negedge clk);
        slv_ar_valid = '0; slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1; mst_r_valid = 1'b1;
        #1;
        total++;
        if (slv_b_valid !== (4'b1 << b_q[0]) || slv_r_valid !== (4'b1 << r_q[0])) begin
            bad++; $display("FAIL pause_resp: b_valid=%b r_valid=%b want req %0d/%0d", slv_b_valid, slv_r_valid, b_q[0], r_q[0]);
        end
        void'(b_q.pop_front()); void'(r_q.pop_front());
        @(negedge clk); idle_inputs(); #1;
        total++;
        if (err_unexp !== 1'b0) begin bad++; $display("FAIL no_err: err_unexp=%b want 0", err_unexp); end
    endtask

    task automatic test_err_reset();
        @(negedge clk); mst_r_valid = 1'b1; #1;
        total++;
        if (mst_r_ready !== 1'b0 || slv_r_valid !== 4'b0000 || err_unexp !== 1'b0) begin
            bad++; $display("FAIL err_unack: r_rdy=%b r_valid=%b err=%b want 0/0000/0", mst_r_ready, slv_r_valid, err_unexp);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); mst_r_valid = 1'b0; #1;
            total++;
            if (err_unexp !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b want 1", err_unexp); end
        end
        @(negedge clk);
        slv_aw_valid = 4'b0010; slv_w_valid = 4'b0010; mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
        @(negedge clk); #1;
        total++;
        if (mst_aw_valid !== 1'b1 || aw_sel !== SW'(1)) begin bad++; $display("FAIL rst_busy: aw_vld=%b aw_sel=%0d want 1/1", mst_aw_valid, aw_sel); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL rst_async: outs=%h want 0", all_outs); end
        idle_inputs();
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL rst_release: outs=%h want 0", all_outs); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_w_before_aw();
        test_max_trans();
        test_rd_wr_same();
        test_pause();
        test_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
